// File: rtl/tx_frame_monitor.sv
// Passive 8N1 receiver that snoops a SOC TX line and queues bytes in an 8-deep FWFT FIFO.
// Optional macro TXMON_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized rx.
module tx_frame_monitor #(
  parameter int unsigned CLK_FREQ = 40000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  input  logic       ready,
  output logic [3:0] level,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned DEPTH = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic rx_meta;
  logic rx_sync;
  logic rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef TXMON_GLITCH_FILTER_EN
  logic [2:0] rx_hist;

  always_ff @(posedge clk) begin
    if (!reset_n) rx_hist <= 3'b111;
    else          rx_hist <= {rx_hist[1:0], rx_sync};
  end

  assign rx_s = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) | (rx_hist[1] & rx_hist[2]);
`else
  assign rx_s = rx_sync;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             push;
  logic             ferr_set;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Receiver: sample mid-bit, counting from the detected falling edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = CNT_W'(HALF - 1);
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_n   = DATA;
            cnt_n     = CNT_W'(DIV - 1);
            bit_idx_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = CNT_W'(DIV - 1);
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0] mem [DEPTH];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [2:0] rd_ptr_n;
  logic [3:0] level_n;
  logic       pop;
  logic       full;
  logic       push_ok;
  logic       ovf_set;
  logic       head_bypass;

  // A push into a FIFO that is (or becomes) empty this cycle lands straight on dout.
  always_comb begin
    pop         = valid & ready;
    full        = (level == 4'(DEPTH));
    push_ok     = push & (~full | pop);
    ovf_set     = push & full & ~pop;
    rd_ptr_n    = rd_ptr + 3'(pop);
    level_n     = level + 4'(push_ok) - 4'(pop);
    head_bypass = push_ok & (level == 4'(pop));
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 3'd1;
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      valid  <= (level_n != 4'd0);
      if (level_n != 4'd0) dout <= head_bypass ? shreg : mem[rd_ptr_n];
    end
  end

  // Sticky flags; a set event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~clr);
      overflow  <= ovf_set | (overflow & ~clr);
    end
  end

endmodule

// File: tb/tb_tx_frame_monitor.sv
// Directed bench for tx_frame_monitor at default parameters (DIV = 347, HALF = 173).
module tb_tx_frame_monitor;

  localparam int DIV  = 347;
  localparam int HALF = 173;
`ifdef TXMON_GLITCH_FILTER_EN
  localparam int         FLT        = 2;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int         FLT        = 0;
  localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif
  // Clock edges from the edge preceding the start bit to the stop-bit sample.
  localparam int PUSH_OFF = 3 + HALF + 9 * DIV + FLT;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       ready;
  logic [3:0] level;
  logic       frame_err;
  logic       overflow;
  logic       clr;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int pop_rd = 0;
  int vc0;
  logic [7:0] popq [$];

  tx_frame_monitor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .dout      (dout),
    .valid     (valid),
    .ready     (ready),
    .level     (level),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted byte and every cycle with valid high.
  always @(negedge clk) begin
    if (reset_n && valid) valid_cycles++;
    if (reset_n && valid && ready) popq.push_back(dout);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_pop(input string tag, input logic [7:0] exp);
    if (pop_rd < popq.size()) check(tag, 32'(popq[pop_rd]), 32'(exp));
    else                      check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(exp));
    pop_rd++;
  endtask

  // Bit slots: 0 start, 1..8 data LSB first, then stop_low low slots, then one high stop slot.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int glitch_c);
    int   total;
    int   idx;
    logic v;
    total = (10 + stop_low) * DIV;
    @(posedge clk); #1 rx = 1'b0;
    for (int c = 1; c < total; c++) begin
      @(posedge clk); #1;
      idx = c / DIV;
      if (idx == 0)                 v = 1'b0;
      else if (idx <= 8)            v = b[idx-1];
      else if (idx < 9 + stop_low)  v = 1'b0;
      else                          v = 1'b1;
      if (c == glitch_c) v = 1'b1;
      rx = v;
    end
    #1 rx = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rx = 1'b1; ready = 1'b0; clr = 1'b0; reset_n = 1'b0;
    idle(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_dout",  32'(dout), 32'h00);
    check("rst_ferr",  32'(frame_err), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    reset_n = 1'b1;
    idle(20);

    // Reset in the middle of a start bit / frame abandons it.
    rx = 1'b0;
    idle(600);
    reset_n = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(20);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);

    // Single frame with consumer always ready.
    ready = 1'b1;
    vc0 = valid_cycles;
    send_frame(8'hA5, 0, -1);
    idle(5);
    check("a5_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    expect_pop("a5_byte", 8'hA5);
    check("a5_level", 32'(level), 32'd0);
    check("a5_ferr", 32'(frame_err), 32'd0);
    check("a5_ovf",  32'(overflow), 32'd0);

    // Nine frames with no consumer: eighth fills, ninth overflows.
    ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, -1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_ovf",   32'(overflow), 32'd1);
    check("fill_dout",  32'(dout), 32'h01);
    check("fill_valid", 32'(valid), 32'd1);
    pulse_clr();
    #1;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Push and pop on the same edge while full.
    fork
      send_frame(8'h0A, 0, -1);
      begin
        @(posedge clk);
        repeat (PUSH_OFF - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("pp_level", 32'(level), 32'd8);
    check("pp_ovf",   32'(overflow), 32'd0);
    expect_pop("pp_pop", 8'h01);
    check("pp_dout",  32'(dout), 32'h02);

    // Overflow coincident with clr: the set wins.
    fork
      send_frame(8'h0B, 0, -1);
      begin
        @(posedge clk);
        repeat (PUSH_OFF - 1) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
      end
    join
    check("clrset_ovf",   32'(overflow), 32'd1);
    check("clrset_level", 32'(level), 32'd8);

    // Drain: oldest first, the dropped 0x0B never appears.
    ready = 1'b1;
    for (int i = 0; i < 20 && level != 4'd0; i++) @(posedge clk);
    #1;
    check("drain_level", 32'(level), 32'd0);
    for (int i = 2; i <= 8; i++) expect_pop("drain_byte", 8'(i));
    expect_pop("drain_last", 8'h0A);
    check("drain_count", 32'(popq.size()), 32'(pop_rd));
    pulse_clr();

    // Stop bit held low for two bit times, then a good frame.
    send_frame(8'h3C, 2, -1);
    check("ferr_set",   32'(frame_err), 32'd1);
    check("ferr_level", 32'(level), 32'd0);
    check("ferr_nopop", 32'(popq.size()), 32'(pop_rd));
    send_frame(8'h55, 0, -1);
    idle(3);
    expect_pop("after_ferr", 8'h55);
    check("ferr_sticky", 32'(frame_err), 32'd1);
    pulse_clr();
    #1;
    check("ferr_clr", 32'(frame_err), 32'd0);

    // Short low pulse is a false start.
    @(posedge clk); #1 rx = 1'b0;
    idle(100);
    rx = 1'b1;
    idle(2 * DIV);
    check("fs_nopop", 32'(popq.size()), 32'(pop_rd));
    check("fs_level", 32'(level), 32'd0);
    check("fs_ferr",  32'(frame_err), 32'd0);
    check("fs_ovf",   32'(overflow), 32'd0);

    // One-cycle high glitch at the bit-3 sample point of 0x00.
    send_frame(8'h00, 0, HALF + 4 * DIV);
    idle(3);
    expect_pop("glitch", GLITCH_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_monitor.md
TX_FRAME_MONITOR -- requirements
Module: tx_frame_monitor

Interface
REQ-001 Parameter: CLK_FREQ, 40000000, system clock frequency in Hz.
REQ-002 Parameter: BAUD, 115200, serial bit rate; DIV = CLK_FREQ/BAUD, truncated (347 at defaults); HALF = DIV/2, truncated (173).
REQ-003 clk  input  1  system clock, single clock domain, all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 rx  input  1  8N1 serial stream from SOC TX pin, asynchronous, idle high.
REQ-006 dout  output  8  head-of-FIFO byte.
REQ-007 valid  output  1  FIFO non-empty; dout is meaningful.
REQ-008 ready  input  1  consumer accepts dout this cycle.
REQ-009 level  output  4  FIFO occupancy, 0..8.
REQ-010 frame_err  output  1  sticky: stop bit sampled low.
REQ-011 overflow  output  1  sticky: byte dropped because FIFO full.
REQ-012 clr  input  1  one-cycle pulse that clears frame_err and overflow.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (rx_s).
REQ-014 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: when rx_s is 0, go to START with bit counter = HALF-1.
REQ-016 START: at counter 0, if rx_s = 0, go to DATA with counter = DIV-1 and bit index = 0; if rx_s = 1 (false start), return to IDLE and push nothing.
REQ-017 DATA: at each counter 0, shift rx_s in LSB first and reload DIV-1; after bit 7, go to STOP with counter = DIV-1.
REQ-018 STOP: at counter 0, if rx_s = 1, push the byte and go to IDLE; if rx_s = 0, set frame_err, discard the byte, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s = 1, then go to IDLE (a break condition yields one frame_err only).
REQ-020 FIFO: 8 entries, first-word fall-through; a pushed byte appears on dout with valid = 1 on the cycle after the stop-bit sample, when the FIFO was empty.
REQ-021 Pop occurs when valid & ready; ready SHALL be ignored while valid = 0.
REQ-022 Push while level = 8 without a same-cycle pop: drop the byte, set overflow, leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle: both take effect and level is unchanged, including at level = 8.
REQ-024 Pointers are 3-bit and wrap modulo 8; level SHALL equal the pushes minus pops exactly.
REQ-025 clr clears both sticky flags; if a set event coincides with clr, the set wins.
REQ-026 Decoding SHALL continue regardless of FIFO state; there is no backpressure on rx.

Reset
REQ-027 While reset_n = 0 at a clock edge: FSM = IDLE, synchronizer and filter flops = 1, pointers = 0, level = 0, valid = 0, frame_err = 0, overflow = 0, dout = 0x00.
REQ-028 Reset asserted mid-frame SHALL abandon the partial byte; after release, decoding resumes at the next falling edge of rx_s.

Configuration
REQ-029 Macro TXMON_GLITCH_FILTER_EN: when defined, rx_s is replaced by a 3-sample majority vote of the last three synchronized samples, adding 2 cycles of latency; single-cycle glitches are then suppressed.
REQ-030 Without TXMON_GLITCH_FILTER_EN, the synchronizer output is used directly and there is no filter logic.

Verification
REQ-031 Frame 0xA5 at BAUD (DIV = 347), ready = 1 -> valid pulses for one cycle with dout = 0xA5; level returns to 0; no flags set.
REQ-032 9 frames 0x01..0x09, ready = 0 -> level = 8, overflow = 1, dout = 0x01; then 8 pops yield 0x01..0x08 in order.
REQ-033 Frame 0x3C with stop bit held low for 2 bit times -> frame_err = 1, level unchanged, next good frame 0x55 is received correctly.
REQ-034 rx low pulse of 100 cycles (< HALF) -> no push, FSM back to IDLE, flags 0.
REQ-035 Level = 8, push and pop in the same cycle -> level stays 8, overflow stays 0, oldest byte popped; clr coincident with a new overflow -> overflow remains 1.
REQ-036 With TXMON_GLITCH_FILTER_EN defined: a 1-cycle high glitch at the sample point of bit 3 of frame 0x00 -> received byte is 0x00; without the macro the same stimulus yields 0x08.
